// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front-end: oversamples the SPI pins on clk, deserialises
// FRAME_BITS-bit host frames and serialises the read-back word onto MISO.
module spi_slave_if #(
  parameter int FRAME_BITS  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic [FRAME_BITS-1:0] spi_rx_data,
  output logic                  spi_rx_done,
  input  logic [FRAME_BITS-1:0] spi_tx_data,
  output logic                  frame_err
);

  localparam int CW = 6;
  localparam logic [CW-1:0] FULL_CNT = CW'(FRAME_BITS);
  localparam logic [CW-1:0] SAT_CNT  = CW'(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    ARMED_WAIT = 2'd0,
    IDLE       = 2'd1,
    ACTIVE     = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   cs_hist_q, cs_hist_d;

  state_e                 state_q, state_d;
  logic [FRAME_BITS-1:0]  rx_sr_q, rx_sr_d;
  logic [FRAME_BITS-1:0]  tx_sr_q, tx_sr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]  rx_data_q, rx_data_d;
  logic                   rx_done_q, rx_done_d;
  logic                   frame_err_q, frame_err_d;
  logic                   miso_q, miso_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;

  // Synchroniser chains and edge-detect history
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sclk_hist_d = sclk_s;
    cs_hist_d   = cs_s;
    sclk_rise_s = sclk_s & ~sclk_hist_q;
    sclk_fall_s = ~sclk_s & sclk_hist_q;
    cs_rise_s   = cs_s & ~cs_hist_q;
    cs_fall_s   = ~cs_s & cs_hist_q;
  end

  // Frame FSM, shift registers and bit counter
  always_comb begin
    state_d     = state_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    cnt_d       = cnt_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ARMED_WAIT: begin
        // Never join a frame that was already running when reset released
        if (cs_s) begin
          state_d = IDLE;
        end else begin
          state_d = ARMED_WAIT;
        end
      end
      IDLE: begin
        if (cs_fall_s) begin
          tx_sr_d = spi_tx_data;
          rx_sr_d = '0;
          cnt_d   = '0;
          state_d = ACTIVE;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (cs_rise_s) begin
          state_d     = IDLE;
          frame_err_d = (cnt_q != FULL_CNT);
        end else begin
          if (sclk_rise_s) begin
            if (cnt_q < FULL_CNT) begin
              rx_sr_d = {rx_sr_q[FRAME_BITS-2:0], mosi_s};
              cnt_d   = cnt_q + CW'(1);
              if (cnt_q == FULL_CNT - CW'(1)) begin
                rx_data_d = {rx_sr_q[FRAME_BITS-2:0], mosi_s};
                rx_done_d = 1'b1;
              end else begin
                rx_done_d = 1'b0;
              end
            end else begin
              cnt_d = SAT_CNT;
            end
          end else begin
            cnt_d = cnt_q;
          end
          if (sclk_fall_s) begin
            tx_sr_d = {tx_sr_q[FRAME_BITS-2:0], 1'b0};
          end else begin
            tx_sr_d = tx_sr_q;
          end
        end
      end
      default: begin
        state_d = ARMED_WAIT;
      end
    endcase

    miso_d = (state_q == ACTIVE) ? tx_sr_q[FRAME_BITS-1] : 1'b0;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b0;
      state_q     <= ARMED_WAIT;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      cnt_q       <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_hist_q <= sclk_hist_d;
      cs_hist_q   <= cs_hist_d;
      state_q     <= state_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      cnt_q       <= cnt_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_rx_data = rx_data_q;
  assign spi_rx_done = rx_done_q;
  assign frame_err   = frame_err_q;

endmodule
